// File: rtl/ti_audio_pkg.sv
// rtl/ti_audio_pkg.sv - shared widths and sample-to-I2S word conversion for the PSG audio path
//
// Purpose: default sample/slot widths and the unsigned-to-two's-complement word mapping
//          used by the I2S transmitter.
// Contents: SAMPLE_W_DEF, SLOT_W_DEF, to_i2s_word().
package ti_audio_pkg;

  localparam int SAMPLE_W_DEF = 15;
  localparam int SLOT_W_DEF   = 16;

  // Offset-binary 15-bit sample -> 16-bit signed slot word.
  // Left-justify, then flip the MSB so midscale (15'h4000) maps to zero.
  function automatic logic [SLOT_W_DEF-1:0] to_i2s_word(input logic [SAMPLE_W_DEF-1:0] u);
    return {u, 1'b0} ^ 16'h8000;
  endfunction

endpackage

// File: rtl/ti_i2s_clkgen.sv
// rtl/ti_i2s_clkgen.sv - BCLK divider with falling-edge event strobe
//
// Purpose: divides CLK by 2*CLK_DIV to make the I2S bit clock and flags the
//          cycle in which BCLK is about to fall so the transmitter can update data.
// Ports:
//   CLK        in   system clock
//   RST        in   synchronous reset, active-high
//   i2s_bclk   out  bit clock (registered)
//   bclk_fall  out  high in the CLK cycle whose posedge drives BCLK low
module ti_i2s_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  output logic i2s_bclk,
  output logic bclk_fall
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          wrap;

  always_comb begin
    wrap      = (div_cnt_q == DW'(CLK_DIV - 1));
    div_cnt_d = wrap ? '0 : div_cnt_q + DW'(1);
    bclk_d    = wrap ? ~bclk_q : bclk_q;
    // The toggle and the event share a cycle: a wrap with BCLK high is a fall.
    bclk_fall = wrap & bclk_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign i2s_bclk = bclk_q;

endmodule

// File: rtl/ti_i2s_tx.sv
// rtl/ti_i2s_tx.sv - Philips I2S serialiser for mono PSG samples with one-deep holding register
//
// Purpose: accepts 15-bit unsigned samples over valid/ready and sends each as a
//          16-bit two's complement word on both left and right I2S slots.
// Ports:
//   CLK           in   system clock
//   RST           in   synchronous reset, active-high
//   sample_in     in   mixed sample (offset binary)
//   sample_valid  in   sample_in valid
//   sample_ready  out  holding register empty (registered)
//   i2s_bclk      out  bit clock
//   i2s_lrclk     out  word select, 0 = left, 1 = right
//   i2s_sdata     out  serial data, MSB first, updated on BCLK fall
//   underrun      out  one-cycle pulse when a frame starts with nothing to send
module ti_i2s_tx
  import ti_audio_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int SLOT_W   = SLOT_W_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                i2s_bclk,
  output logic                i2s_lrclk,
  output logic                i2s_sdata,
  output logic                underrun
);

  localparam int BCW = $clog2(2 * SLOT_W);
  localparam int IW  = $clog2(SLOT_W);

  logic bclk_fall;

  ti_i2s_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .CLK       (CLK),
    .RST       (RST),
    .i2s_bclk  (i2s_bclk),
    .bclk_fall (bclk_fall)
  );

  logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic [SLOT_W-1:0]   frame_q, frame_d;
  logic                underrun_q, underrun_d;

  logic [BCW-1:0] k;
  logic [IW-1:0]  idx;
  logic           load;

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    frame_d     = frame_q;
    underrun_d  = 1'b0;

    k    = bit_cnt_q + BCW'(1);
    // (k-1) mod SLOT_W is just the low bits of the current count.
    idx  = IW'(SLOT_W - 1) - bit_cnt_q[IW-1:0];
    // k==1 is the fall that puts the left-slot MSB out: the frame boundary.
    load = bclk_fall && (k == BCW'(1));

    if (load) begin
      if (hold_full_q) begin
        frame_d     = to_i2s_word(hold_q);
        hold_full_d = 1'b0;
      end else if (sample_valid) begin
        // Producer arrived just in time: take it straight into the frame.
        frame_d = to_i2s_word(sample_in);
      end else begin
        underrun_d = 1'b1;
      end
    end else if (sample_valid && !hold_full_q) begin
      hold_d      = sample_in;
      hold_full_d = 1'b1;
    end

    if (bclk_fall) begin
      bit_cnt_d = k;
      lrclk_d   = (k >= BCW'(SLOT_W));
      // Select from the next-frame value so the new word's MSB goes out at k==1.
      sdata_d   = frame_d[idx];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt_q   <= '1;
      lrclk_q     <= 1'b1;
      sdata_q     <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      frame_q     <= '0;
      underrun_q  <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      frame_q     <= frame_d;
      underrun_q  <= underrun_d;
    end
  end

  assign sample_ready = ~hold_full_q;
  assign i2s_lrclk    = lrclk_q;
  assign i2s_sdata    = sdata_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_ti_i2s_tx.sv
// tb/tb_ti_i2s_tx.sv - scoreboard bench for the I2S transmitter
module tb_ti_i2s_tx;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [14:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        underrun;

  ti_i2s_tx dut (
    .CLK          (CLK),
    .RST          (RST),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .underrun     (underrun)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] expw(input logic [14:0] u);
    return {~u[14], u[13:0], 1'b0};
  endfunction

  // Scoreboard state
  logic [15:0] pend[$];
  int          mk = 31;
  logic        prev_bclk = 1'b0;
  bit          frame_ok = 1'b0;
  logic [15:0] cur_exp = 16'h0000;
  logic [15:0] shreg = 16'h0000;
  int          frames_done = 0;
  bit          fall_now = 1'b0;
  bit          rst_at_edge = 1'b1;
  int          cyc = 0;

  always @(posedge CLK) begin
    rst_at_edge <= RST;
    cyc <= cyc + 1;
  end

  always @(negedge CLK) begin : mon
    logic fall, rise, exp_u;
    if (rst_at_edge) begin
      mk = 31;
      prev_bclk = 1'b0;
      frame_ok = 1'b0;
      cur_exp = 16'h0000;
      shreg = 16'h0000;
      pend.delete();
      fall_now = 1'b0;
    end else begin
      fall  = prev_bclk && !i2s_bclk;
      rise  = !prev_bclk && i2s_bclk;
      exp_u = 1'b0;
      if (fall) begin
        mk = (mk + 1) % 32;
        chk("lrclk", i2s_lrclk, (mk >= 16));
        if (mk == 1) begin
          if (pend.size() > 0) cur_exp = pend.pop_front();
          else exp_u = 1'b1;
          frame_ok = 1'b1;
          chk("ready_at_load", sample_ready, 1);
        end
      end
      chk("underrun", underrun, exp_u);
      if (rise) begin
        shreg = {shreg[14:0], i2s_sdata};
        if (frame_ok && mk == 16) chk("left_slot", shreg, cur_exp);
        if (frame_ok && mk == 0) begin
          chk("right_slot", shreg, cur_exp);
          frames_done++;
        end
      end
      prev_bclk = i2s_bclk;
      fall_now = fall;
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic send(input logic [14:0] s);
    bit sent = 1'b0;
    sample_in = s;
    sample_valid = 1'b1;
    for (int i = 0; i < 1000 && !sent; i++) begin
      if (sample_ready) begin
        pend.push_back(expw(s));
        sent = 1'b1;
      end
      step();
    end
    sample_valid = 1'b0;
    chk("send_done", sent, 1);
  endtask

  task automatic wait_frames(input int n);
    int target = frames_done + n;
    for (int i = 0; i < 300 * n && frames_done < target; i++) step();
    chk("frames_done", (frames_done >= target), 1);
  endtask

  task automatic check_reset_and_first_rise();
    int cnt = 0;
    chk("rst_bclk", i2s_bclk, 0);
    chk("rst_lrclk", i2s_lrclk, 1);
    chk("rst_sdata", i2s_sdata, 0);
    chk("rst_ready", sample_ready, 1);
    chk("rst_underrun", underrun, 0);
    RST = 1'b0;
    do begin
      step();
      cnt++;
    end while (!i2s_bclk && cnt < 20);
    chk("first_rise", cnt, 4);
  endtask

  int acc_t[5];

  initial begin
    int acc;
    bit found;

    // Reset held three cycles
    RST = 1'b1;
    repeat (3) step();
    check_reset_and_first_rise();

    // Full-scale sample before the first frame boundary
    send(15'h7FFF);
    wait_frames(1);

    // Two successive frames
    send(15'h0000);
    send(15'h4000);
    wait_frames(2);

    // Starvation after 15'h1234: repeat and underrun
    send(15'h1234);
    wait_frames(3);

    // Continuous valid with incrementing data
    sample_in = 15'h0100;
    sample_valid = 1'b1;
    acc = 0;
    for (int t = 0; t < 3000 && acc < 5; t++) begin
      if (sample_ready) begin
        pend.push_back(expw(sample_in));
        acc_t[acc] = cyc;
        acc++;
        step();
        sample_in = sample_in + 15'd1;
      end else begin
        step();
      end
    end
    sample_valid = 1'b0;
    chk("stream_count", acc, 5);
    for (int i = 2; i < 5; i++) chk("stream_interval", acc_t[i] - acc_t[i-1], 256);
    wait_frames(2);

    // Valid exactly on the k==1 fall with hold empty
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      step();
      if (fall_now && mk == 0) found = 1'b1;
    end
    chk("find_k0", found, 1);
    repeat (7) step();
    chk("bypass_ready", sample_ready, 1);
    sample_in = 15'h2AAA;
    sample_valid = 1'b1;
    pend.push_back(expw(15'h2AAA));
    step();
    sample_valid = 1'b0;
    chk("bypass_hold_empty", sample_ready, 1);
    wait_frames(2);
    chk("pend_drained", pend.size(), 0);

    // Reset in the middle of the right slot
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      step();
      if (mk == 20) found = 1'b1;
    end
    chk("find_k20", found, 1);
    RST = 1'b1;
    step();
    check_reset_and_first_rise();
    wait_frames(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
